// File: rtl/mismatch_monitor.sv
// Sample-by-sample comparator of a DUT against a reference with a don't-care mask.
// Counts samples and mismatches per run and records the index of the first mismatch.
module mismatch_monitor #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_samples,
  input  logic [WIDTH-1:0] ref_val,
  input  logic [WIDTH-1:0] dut_val,
  input  logic [WIDTH-1:0] care_mask,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] samples,
  output logic [CNT_W-1:0] errors,
  output logic             has_err,
  output logic [CNT_W-1:0] first_err
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] samples_q, samples_d;
  logic [CNT_W-1:0] errors_q, errors_d;
  logic [CNT_W-1:0] first_q, first_d;
  logic             has_q, has_d;
  logic             busy_q, done_q;
  logic             mismatch;
  logic [CNT_W-1:0] samples_inc;

  assign mismatch    = |((ref_val ^ dut_val) & care_mask);
  assign samples_inc = samples_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    samples_d = samples_q;
    errors_d  = errors_q;
    first_d   = first_q;
    has_d     = has_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          len_d     = num_samples;
          samples_d = '0;
          errors_d  = '0;
          first_d   = '0;
          has_d     = 1'b0;
          // A zero-length run skips RUN and just produces the done pulse.
          state_d   = (num_samples != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StDone;
        end else begin
          samples_d = samples_inc;
          if (mismatch) begin
            if (errors_q != '1) errors_d = errors_q + CNT_W'(1);
            if (!has_q) begin
              has_d   = 1'b1;
              first_d = samples_q;
            end
          end
          if (samples_inc == len_q) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      len_q     <= '0;
      samples_q <= '0;
      errors_q  <= '0;
      first_q   <= '0;
      has_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      samples_q <= samples_d;
      errors_q  <= errors_d;
      first_q   <= first_d;
      has_q     <= has_d;
      busy_q    <= (state_d == StRun);
      done_q    <= (state_d == StDone);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign samples   = samples_q;
  assign errors    = errors_q;
  assign has_err   = has_q;
  assign first_err = first_q;

endmodule

// File: doc/mismatch_monitor.md
MISMATCH_MONITOR -- requirements
Module: mismatch_monitor

Interface
REQ-001 Parameter WIDTH, default 1: width of compared vectors.
REQ-002 Parameter CNT_W, default 16: width of sample/error counters and num_samples.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin a run; sampled only in IDLE.
REQ-006 abort  input  1  end the current run early; sampled only in RUN.
REQ-007 num_samples  input  CNT_W  run length in samples; latched on accepted start.
REQ-008 ref_val  input  WIDTH  reference model output.
REQ-009 dut_val  input  WIDTH  device-under-test output.
REQ-010 care_mask  input  WIDTH  1 = bit compared, 0 = don't-care (reference unknown).
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  one-cycle pulse when a run ends.
REQ-013 samples  output  CNT_W  samples taken in current/last run.
REQ-014 errors  output  CNT_W  mismatching samples in current/last run.
REQ-015 has_err  output  1  at least one mismatch in current/last run.
REQ-016 first_err  output  CNT_W  zero-based sample index of first mismatch; valid when has_err=1.

Function
REQ-017 State machine SHALL have states IDLE, RUN, DONE; all outputs registered.
REQ-018 IDLE: start=1 and num_samples>0 -> latch num_samples, clear samples/errors/has_err/first_err, next state RUN.
REQ-019 IDLE: start=1 and num_samples=0 -> clear counters, next state DONE (empty run, no sample taken).
REQ-020 IDLE: start=0 -> remain IDLE, counters hold last run's results.
REQ-021 RUN: each cycle takes exactly one sample; mismatch = OR-reduce((ref_val XOR dut_val) AND care_mask).
REQ-022 RUN sample: samples increments by 1; if mismatch, errors increments by 1, saturating at 2^CNT_W-1.
REQ-023 RUN sample with mismatch and has_err=0: first_err <= current samples value (pre-increment), has_err <= 1; later mismatches do not change first_err.
REQ-024 RUN: when the sample taken makes samples equal latched num_samples, next state DONE; first sample occurs the cycle after start accepted, so a run of N lasts N cycles in RUN.
REQ-025 RUN: abort=1 -> next state DONE; that cycle's sample SHALL NOT be counted; abort has priority over terminal count.
REQ-026 start in RUN or DONE SHALL be ignored (no restart, no re-latch).
REQ-027 abort outside RUN SHALL be ignored.
REQ-028 DONE: done=1 for exactly that cycle, busy=0, next state IDLE; counters frozen.
REQ-029 busy=1 exactly in RUN; done=1 exactly in DONE.
REQ-030 Changes to num_samples during RUN SHALL NOT affect the active run.

Reset
REQ-031 reset=1 SHALL force IDLE next cycle, busy=0, done=0, samples=0, errors=0, has_err=0, first_err=0, latched length=0.
REQ-032 reset SHALL take priority over start, abort and any in-progress run; no done pulse SHALL be generated by a reset mid-run.

Verification
REQ-033 WIDTH=1, CNT_W=16: start with num_samples=20, ref_val=dut_val=0 throughout -> busy high 20 cycles, done pulse once, samples=20, errors=0, has_err=0.
REQ-034 num_samples=10, dut_val=1 only on samples 3 and 7 (ref 0, mask 1) -> errors=2, has_err=1, first_err=3, samples=10.
REQ-035 care_mask=0, ref_val≠dut_val every cycle, num_samples=8 -> errors=0, has_err=0, samples=8.
REQ-036 num_samples=10, abort asserted on 5th RUN cycle -> samples=4, done pulses next cycle, busy low afterwards; start pulses during RUN ignored.
REQ-037 num_samples=0 start -> no RUN cycle, done pulse the next cycle, samples=0; then reset mid-run of length 50 at sample 25 -> all outputs 0, no done pulse, IDLE.
REQ-038 CNT_W=4, num_samples=15, mismatch every sample -> errors=15 (saturation boundary), first_err=0, samples=15.
